i2c_cfg_sequencer: RTL and testbench

//  Walks a camera register table and feeds one 32-bit word per transaction to send_i2c

---
 rtl/cfg_seq_pkg.sv | 26 ++
 rtl/cfg_delay_timer.sv | 46 ++++
 rtl/i2c_cfg_sequencer.sv | 128 ++++++++++++
 tb/tb_i2c_cfg_sequencer.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cfg_seq_pkg.sv
// Shared types and constants for the camera register-table sequencer.
// States, table-word markers and a small state classification helper.
package cfg_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_PWR_WAIT,
    ST_FETCH,
    ST_DECODE,
    ST_REQ,
    ST_WAIT_ACK,
    ST_GAP,
    ST_DELAY,
    ST_DONE,
    ST_ERR
  } cfg_state_e;

  localparam logic [31:0] END_MARK = 32'hFFFF_FFFF;
  localparam logic [7:0]  DELAY_OP = 8'hFE;

  // A sequence is in progress in every state except the three resting ones.
  function automatic logic is_active(input cfg_state_e s);
    return !(s == ST_IDLE || s == ST_DONE || s == ST_ERR);
  endfunction

endpackage

// File: rtl/cfg_delay_timer.sv
// Millisecond delay timer: load a count of ms, pulses expired once it has elapsed.
// A load of 0 ms expires on the cycle after the load.
module cfg_delay_timer #(
  parameter int MS_CYCLES = 100000
) (
  input  logic        clk_100,
  input  logic        rst_100,
  input  logic        load,
  input  logic [15:0] load_ms,
  output logic        expired
);

  logic [31:0] cyc_reg;
  logic [15:0] ms_left_reg;
  logic        running_reg;
  logic        expired_reg;

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      cyc_reg     <= '0;
      ms_left_reg <= '0;
      running_reg <= 1'b0;
      expired_reg <= 1'b0;
    end else begin
      expired_reg <= 1'b0;
      if (load) begin
        cyc_reg     <= '0;
        ms_left_reg <= load_ms;
        running_reg <= 1'b1;
      end else if (running_reg) begin
        if (ms_left_reg == 16'd0) begin
          running_reg <= 1'b0;
          expired_reg <= 1'b1;
        end else if (cyc_reg == 32'(MS_CYCLES - 1)) begin
          cyc_reg     <= '0;
          ms_left_reg <= ms_left_reg - 16'd1;
        end else begin
          cyc_reg <= cyc_reg + 32'd1;
        end
      end
    end
  end

  assign expired = expired_reg;

endmodule

// File: rtl/i2c_cfg_sequencer.sv
// Walks the camera register table and hands each write word to send_i2c.
// Handles power-up settle, inline ms delays, end-of-table and ack timeout.
module i2c_cfg_sequencer
  import cfg_seq_pkg::*;
#(
  parameter int NUM_REGS    = 256,
  parameter int PWRUP_MS    = 20,
  parameter int MS_CYCLES   = 100000,
  parameter int GAP_CYCLES  = 1000,
  parameter int ACK_TIMEOUT = 1000000,
  parameter int AUTO_START  = 1,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic          clk_100,
  input  logic          rst_100,
  input  logic          start,
  output logic [AW-1:0] rom_addr,
  input  logic [31:0]   rom_data,
  output logic [31:0]   cfg_data,
  output logic          i2c_req,
  input  logic          i2c_ack,
  output logic          cfg_busy,
  output logic          cfg_done,
  output logic          cfg_err,
  output logic [AW-1:0] err_addr
);

  localparam logic [AW-1:0] LAST_ADDR   = AW'(NUM_REGS - 1);
  localparam cfg_state_e    RESET_STATE = (AUTO_START != 0) ? ST_PWR_WAIT : ST_IDLE;

  cfg_state_e    state_reg, state_next;
  logic [AW-1:0] rom_addr_reg, rom_addr_next, err_addr_reg;
  logic [31:0]   cfg_data_reg, cnt_reg;
  logic          req_reg, busy_reg, done_reg, err_reg, arm_reg;
  logic          advance, tmr_load, tmr_expired;
  logic [15:0]   tmr_ms;

  always_comb begin
    state_next    = state_reg;
    rom_addr_next = rom_addr_reg;
    advance       = 1'b0;
    case (state_reg)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_next    = ST_PWR_WAIT;
          rom_addr_next = '0;
        end
      end
      ST_PWR_WAIT: if (tmr_expired) state_next = ST_FETCH;
      ST_FETCH:    state_next = ST_DECODE;
      ST_DECODE: begin
        if (rom_data == END_MARK)            state_next = ST_DONE;
        else if (rom_data[31:24] == DELAY_OP) begin
          if (rom_data[15:0] == 16'd0) advance = 1'b1;
          else                         state_next = ST_DELAY;
        end else                             state_next = ST_REQ;
      end
      ST_REQ: state_next = ST_WAIT_ACK;
      ST_WAIT_ACK: begin
        if (i2c_ack)                                state_next = ST_GAP;
        else if (cnt_reg == 32'(ACK_TIMEOUT - 1))   state_next = ST_ERR;
      end
      ST_GAP:   if (cnt_reg == 32'(GAP_CYCLES - 1)) advance = 1'b1;
      ST_DELAY: if (tmr_expired) advance = 1'b1;
      default:  state_next = ST_IDLE;
    endcase
    // The last table slot is an implicit end marker once its word is handled.
    if (advance) begin
      if (rom_addr_reg == LAST_ADDR) begin
        state_next = ST_DONE;
      end else begin
        state_next    = ST_FETCH;
        rom_addr_next = rom_addr_reg + 1'b1;
      end
    end
  end

  // arm_reg kicks off the power-up settle when the sequence auto-starts out of reset.
  assign tmr_load = arm_reg
                 || (state_next == ST_PWR_WAIT && state_reg != ST_PWR_WAIT)
                 || (state_next == ST_DELAY && state_reg != ST_DELAY);
  assign tmr_ms   = (state_reg == ST_DECODE) ? rom_data[15:0] : 16'(PWRUP_MS);

  always_ff @(posedge clk_100) begin
    if (rst_100) begin
      state_reg    <= RESET_STATE;
      rom_addr_reg <= '0;
      err_addr_reg <= '0;
      cfg_data_reg <= '0;
      cnt_reg      <= '0;
      req_reg      <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      err_reg      <= 1'b0;
      arm_reg      <= (AUTO_START != 0);
    end else begin
      state_reg    <= state_next;
      rom_addr_reg <= rom_addr_next;
      arm_reg      <= 1'b0;
      cnt_reg      <= (state_next != state_reg) ? 32'd0 : cnt_reg + 32'd1;
      req_reg      <= (state_next == ST_REQ);
      busy_reg     <= is_active(state_next);
      done_reg     <= (state_next == ST_DONE);
      err_reg      <= (state_next == ST_ERR);
      if (state_next == ST_REQ) cfg_data_reg <= rom_data;
      if (state_reg == ST_WAIT_ACK && state_next == ST_ERR) err_addr_reg <= rom_addr_reg;
    end
  end

  cfg_delay_timer #(
    .MS_CYCLES(MS_CYCLES)
  ) u_delay_timer (
    .clk_100(clk_100),
    .rst_100(rst_100),
    .load   (tmr_load),
    .load_ms(tmr_ms),
    .expired(tmr_expired)
  );

  assign rom_addr = rom_addr_reg;
  assign cfg_data = cfg_data_reg;
  assign i2c_req  = req_reg;
  assign cfg_busy = busy_reg;
  assign cfg_done = done_reg;
  assign cfg_err  = err_reg;
  assign err_addr = err_addr_reg;

endmodule

// File: tb/tb_i2c_cfg_sequencer.sv
// Bench for i2c_cfg_sequencer: ROM and send_i2c models plus a table-walking reference.
// Uses a 4-entry table with shortened timing constants.
module tb_i2c_cfg_sequencer;

  localparam int NUM_REGS = 4;
  localparam int AW       = 2;
  localparam int ACK_LAT  = 30;

  logic          clk_100 = 1'b0;
  logic          rst_100 = 1'b1;
  logic          start   = 1'b0;
  logic          i2c_ack = 1'b0;
  logic [AW-1:0] rom_addr, err_addr;
  logic [31:0]   rom_data, cfg_data;
  logic          i2c_req, cfg_busy, cfg_done, cfg_err;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [31:0] rom [NUM_REGS];
  int          no_ack_addr = -1;
  int          ack_cnt = 0;
  int          req_wide = 0;
  logic        req_prev = 1'b0;
  logic [31:0] req_q[$];
  int          req_cyc_q[$];
  int          ack_cyc_q[$];
  int          rel_cyc, end_cyc;

  logic [31:0] exp_q[$];
  logic        exp_done, exp_err;
  int          exp_addr, exp_err_addr;

  i2c_cfg_sequencer #(
    .NUM_REGS(NUM_REGS), .PWRUP_MS(2), .MS_CYCLES(10),
    .GAP_CYCLES(4), .ACK_TIMEOUT(50), .AUTO_START(1)
  ) dut (
    .clk_100(clk_100), .rst_100(rst_100), .start(start),
    .rom_addr(rom_addr), .rom_data(rom_data), .cfg_data(cfg_data),
    .i2c_req(i2c_req), .i2c_ack(i2c_ack), .cfg_busy(cfg_busy),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .err_addr(err_addr)
  );

  always #5 clk_100 = ~clk_100;

  always @(posedge clk_100) begin
    rom_data <= rom[rom_addr];
    cyc      <= cyc + 1;
  end

  // send_i2c model: acks ACK_LAT cycles after each req unless told to stay silent.
  always @(negedge clk_100) begin
    i2c_ack = 1'b0;
    if (rst_100) begin
      ack_cnt = 0;
    end else if (ack_cnt > 0) begin
      ack_cnt = ack_cnt - 1;
      if (ack_cnt == 0) begin
        i2c_ack = 1'b1;
        ack_cyc_q.push_back(cyc);
      end
    end
    if (i2c_req === 1'b1) begin
      if (req_prev) req_wide++;
      req_q.push_back(cfg_data);
      req_cyc_q.push_back(cyc);
      if (int'(rom_addr) != no_ack_addr) ack_cnt = ACK_LAT;
    end
    req_prev = (i2c_req === 1'b1);
  end

  // Reference: walk the table and list the words that should reach the bus.
  function automatic void run_model();
    exp_q.delete();
    exp_done = 1'b0; exp_err = 1'b0; exp_addr = 0; exp_err_addr = 0;
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_addr = i;
      if (rom[i] == 32'hFFFF_FFFF) begin exp_done = 1'b1; return; end
      if (rom[i][31:24] == 8'hFE) continue;
      exp_q.push_back(rom[i]);
      if (i == no_ack_addr) begin exp_err = 1'b1; exp_err_addr = i; return; end
    end
    exp_done = 1'b1;
  endfunction

  function automatic logic [31:0] rand_write();
    return {8'($urandom_range(0, 8'hEF)), 24'($urandom)};
  endfunction

  task automatic apply_reset();
    @(negedge clk_100);
    rst_100 = 1'b1;
    start   = 1'b0;
    repeat (3) @(negedge clk_100);
    req_q.delete(); req_cyc_q.delete(); ack_cyc_q.delete();
    req_wide = 0;
    rst_100  = 1'b0;
    rel_cyc  = cyc;
  endtask

  task automatic wait_end(input int budget, input string tag);
    int n = 0;
    while (!((cfg_done || cfg_err) && !cfg_busy) && n < budget) begin
      @(negedge clk_100);
      n++;
    end
    end_cyc = cyc;
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s_end_timeout: busy=%0b done=%0b err=%0b after %0d cycles", tag, cfg_busy, cfg_done, cfg_err, n);
    end
  endtask

  task automatic pulse_start();
    @(negedge clk_100); start = 1'b1;
    @(negedge clk_100); start = 1'b0;
    @(negedge clk_100);
  endtask

  task automatic check_run(input string tag);
    checks++;
    if (req_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL %s_req_count: got %0d expected %0d", tag, req_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < req_q.size(); i++) begin
      checks++;
      if (req_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL %s_cfg_data[%0d]: got %08h expected %08h", tag, i, req_q[i], exp_q[i]);
      end
    end
    checks++;
    if (cfg_done !== exp_done || cfg_err !== exp_err || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_status: done=%0b err=%0b busy=%0b expected done=%0b err=%0b busy=0", tag, cfg_done, cfg_err, cfg_busy, exp_done, exp_err);
    end
    checks++;
    if (rom_addr !== AW'(exp_addr)) begin
      errors++;
      $display("FAIL %s_rom_addr: got %0d expected %0d", tag, rom_addr, exp_addr);
    end
    if (exp_err) begin
      checks++;
      if (err_addr !== AW'(exp_err_addr)) begin
        errors++;
        $display("FAIL %s_err_addr: got %0d expected %0d", tag, err_addr, exp_err_addr);
      end
    end
    checks++;
    if (req_wide != 0) begin
      errors++;
      $display("FAIL %s_req_width: req high on %0d consecutive cycles, expected 0", tag, req_wide);
    end
    $display("run %s: reqs=%0d done=%0b err=%0b rom_addr=%0d", tag, req_q.size(), cfg_done, cfg_err, rom_addr);
  endtask

  task automatic test_reset();
    for (int i = 0; i < NUM_REGS; i++) rom[i] = rand_write();
    @(negedge clk_100); rst_100 = 1'b1;
    repeat (3) @(negedge clk_100);
    checks++;
    if ({i2c_req, cfg_busy, cfg_done, cfg_err} !== 4'b0 || rom_addr !== '0 || err_addr !== '0 || cfg_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs: req=%0b busy=%0b done=%0b err=%0b addr=%0d err_addr=%0d data=%08h expected all 0",
               i2c_req, cfg_busy, cfg_done, cfg_err, rom_addr, err_addr, cfg_data);
    end
    $display("reset: outputs req=%0b busy=%0b done=%0b err=%0b", i2c_req, cfg_busy, cfg_done, cfg_err);
  endtask

  task automatic test_basic();
    no_ack_addr = -1;
    rom[0] = rand_write(); rom[1] = rand_write(); rom[2] = 32'hFFFF_FFFF; rom[3] = rand_write();
    run_model();
    apply_reset();
    wait_end(2000, "basic");
    check_run("basic");
    checks++;
    if (req_cyc_q.size() == 0 || req_cyc_q[0] - rel_cyc < 20) begin
      errors++;
      $display("FAIL basic_pwrup: first req %0d cycles after reset release, required >= 20",
               (req_cyc_q.size() == 0) ? -1 : req_cyc_q[0] - rel_cyc);
    end
  endtask

  task automatic test_delay();
    no_ack_addr = -1;
    rom[0] = rand_write(); rom[1] = 32'hFE00_0003; rom[2] = rand_write(); rom[3] = 32'hFFFF_FFFF;
    run_model();
    apply_reset();
    wait_end(2000, "delay");
    check_run("delay");
    checks++;
    if (req_cyc_q.size() < 2 || ack_cyc_q.size() < 1 || req_cyc_q[1] - ack_cyc_q[0] < 30) begin
      errors++;
      $display("FAIL delay_gap: req after delay came %0d cycles after prior ack, required >= 30",
               (req_cyc_q.size() < 2 || ack_cyc_q.size() < 1) ? -1 : req_cyc_q[1] - ack_cyc_q[0]);
    end
  endtask

  task automatic test_timeout();
    no_ack_addr = 1;
    rom[0] = rand_write(); rom[1] = rand_write(); rom[2] = rand_write(); rom[3] = 32'hFFFF_FFFF;
    run_model();
    apply_reset();
    wait_end(2000, "timeout");
    repeat (100) @(negedge clk_100);
    check_run("timeout");
    checks++;
    if (req_cyc_q.size() < 2 || end_cyc - req_cyc_q[1] < 50 || end_cyc - req_cyc_q[1] > 52) begin
      errors++;
      $display("FAIL timeout_latency: err rose %0d cycles after req, required 50..52",
               (req_cyc_q.size() < 2) ? -1 : end_cyc - req_cyc_q[1]);
    end
    no_ack_addr = -1;
  endtask

  task automatic test_start_busy_and_done();
    int n = 0;
    no_ack_addr = -1;
    rom[0] = rand_write(); rom[1] = rand_write(); rom[2] = 32'hFFFF_FFFF; rom[3] = rand_write();
    run_model();
    apply_reset();
    while (req_q.size() == 0 && n < 500) begin @(negedge clk_100); n++; end
    pulse_start();
    wait_end(2000, "start_busy");
    check_run("start_busy");
    // Rerun from DONE: the same two words must appear again.
    exp_q.push_back(rom[0]);
    exp_q.push_back(rom[1]);
    pulse_start();
    wait_end(2000, "start_done");
    check_run("start_done");
  endtask

  task automatic test_reset_mid();
    int n = 0;
    no_ack_addr = -1;
    rom[0] = rand_write(); rom[1] = rand_write(); rom[2] = 32'hFFFF_FFFF; rom[3] = rand_write();
    run_model();
    apply_reset();
    while (req_q.size() == 0 && n < 500) begin @(negedge clk_100); n++; end
    repeat (5) @(negedge clk_100);
    rst_100 = 1'b1;
    @(negedge clk_100);
    checks++;
    if (i2c_req !== 1'b0 || cfg_busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: req=%0b busy=%0b expected 0 0", i2c_req, cfg_busy);
    end
    $display("reset_mid: req=%0b busy=%0b", i2c_req, cfg_busy);
    apply_reset();
    wait_end(2000, "reset_mid");
    check_run("reset_mid");
  endtask

  task automatic test_random_tables();
    for (int it = 0; it < 6; it++) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        int pick = (it == 0) ? 0 : $urandom_range(0, 9);
        if (pick < 6)      rom[i] = rand_write();
        else if (pick < 9) rom[i] = {8'hFE, 8'($urandom), 16'($urandom_range(0, 2))};
        else               rom[i] = 32'hFFFF_FFFF;
      end
      no_ack_addr = (it != 0 && $urandom_range(0, 3) == 0) ? $urandom_range(0, NUM_REGS - 1) : -1;
      run_model();
      apply_reset();
      wait_end(3000, "random");
      repeat (10) @(negedge clk_100);
      check_run($sformatf("random%0d", it));
    end
    no_ack_addr = -1;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_delay();
    test_timeout();
    test_start_busy_and_done();
    test_reset_mid();
    test_random_tables();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
